// File: rtl/demo_rx.sv
// demo_rx: valid/ready receive FIFO with release gating, plus a phase/lag guarded observation port.
// Optional DEMO_RX_STATS_EN adds saturating accept (rx_count) and overflow-cycle (drop_count) counters.
module demo_rx #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             release_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] leak_out,
  output logic             overflow
`ifdef DEMO_RX_STATS_EN
  ,
  output logic [15:0]      rx_count,
  output logic [7:0]       drop_count
`endif
);

  localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       phase;
  logic [1:0]       lag;
  logic [WIDTH-1:0] guard;

  logic full;
  logic empty;
  logic accept;
  logic pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  // Ready depends only on occupancy, so a full FIFO refuses even when a pop is in flight.
  assign in_ready  = !full;
  assign out_valid = !empty && release_en;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = empty ? '0 : mem[rd_ptr];

  // guard is only nonzero right after a phase-3 accept, where lag is 3, so this
  // port can only ever show 0 or 1.
  assign leak_out  = (lag == 2'd1) ? guard + WIDTH'(1) : '0;

  // NOTE: storage array has no reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= 2'd0;
      lag      <= 2'd3;
      guard    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= phase + 2'd1;
        lag    <= lag + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      guard <= (accept && phase == 2'd3) ? in_data : '0;
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef DEMO_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (accept && rx_count != 16'hFFFF) begin
        rx_count <= rx_count + 16'd1;
      end
      if (in_valid && !in_ready && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demo_rx.sv
// Self-checking bench for demo_rx: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_demo_rx;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             release_en;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [WIDTH-1:0] leak_out;
  logic             overflow;
`ifdef DEMO_RX_STATS_EN
  logic [15:0]      rx_count;
  logic [7:0]       drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demo_rx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .release_en (release_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .leak_out   (leak_out),
    .overflow   (overflow)
`ifdef DEMO_RX_STATS_EN
    ,
    .rx_count   (rx_count),
    .drop_count (drop_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words plus the accept tally and the guard value.
  logic [31:0] q[$];
  int          acc_total;
  logic [31:0] m_guard;
  bit          m_ovf;
  bit          m_valid = 1'b0;
`ifdef DEMO_RX_STATS_EN
  int          m_rx;
  int          m_drop;
`endif

  always @(negedge clk) begin
    logic [31:0] exp_data;
    logic [31:0] exp_leak;
    int          lag_v;
    bit          full_v;
    bit          acc_v;
    bit          pop_v;
    if (m_valid) begin
      lag_v    = (acc_total + 3) % 4;
      exp_data = (q.size() != 0) ? q[0] : 32'h0;
      exp_leak = (lag_v == 1) ? m_guard + 32'd1 : 32'h0;
      check("cmp_in_ready",  {31'b0, in_ready},  {31'b0, q.size() != DEPTH});
      check("cmp_out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0) && release_en});
      check("cmp_out_data",  out_data, exp_data);
      check("cmp_leak_out",  leak_out, exp_leak);
      check("cmp_leak_range", {31'b0, leak_out > 32'd1}, 32'd0);
      check("cmp_overflow",  {31'b0, overflow}, {31'b0, m_ovf});
`ifdef DEMO_RX_STATS_EN
      check("cmp_rx_count",   {16'b0, rx_count},  m_rx);
      check("cmp_drop_count", {24'b0, drop_count}, m_drop);
`endif
    end
    // Advance the model to the state after the coming posedge.
    if (!rst_n) begin
      q.delete();
      acc_total = 0;
      m_guard   = 32'h0;
      m_ovf     = 1'b0;
`ifdef DEMO_RX_STATS_EN
      m_rx      = 0;
      m_drop    = 0;
`endif
      m_valid   = 1'b1;
    end else if (m_valid) begin
      full_v  = (q.size() == DEPTH);
      acc_v   = in_valid && !full_v;
      pop_v   = (q.size() != 0) && release_en && out_ready;
      m_guard = (acc_v && (acc_total % 4 == 3)) ? in_data : 32'h0;
      if (in_valid && full_v) m_ovf = 1'b1;
`ifdef DEMO_RX_STATS_EN
      if (acc_v && m_rx < 16'hFFFF) m_rx++;
      if (in_valid && full_v && m_drop < 8'hFF) m_drop++;
`endif
      if (pop_v) void'(q.pop_front());
      if (acc_v) begin
        q.push_back(in_data);
        acc_total++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n    = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [4];
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    release_en = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state.
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_leak_out",  leak_out, 32'd0);
    check("rst_overflow",  {31'b0, overflow}, 32'd0);

    // Single word, next-cycle visibility and pop.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; release_en = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("one_out_valid", {31'b0, out_valid}, 32'd1);
    check("one_out_data",  out_data, 32'hDEADBEEF);
    step();
    check("one_drained", {31'b0, out_valid}, 32'd0);
    check("one_in_ready", {31'b0, in_ready}, 32'd1);

    // Fill with release held off, overflow on the fifth offer, then drain in order.
    do_reset();
    release_en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'hA000_0000 + i;
      step();
      if (i == 3) check("fill_in_ready_low", {31'b0, in_ready}, 32'd0);
      if (i == 3) check("fill_no_ovf_yet",   {31'b0, overflow}, 32'd0);
      if (i == 4) check("fill_overflow",     {31'b0, overflow}, 32'd1);
    end
    in_valid = 1'b0; release_en = 1'b1; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'b0, out_valid}, 32'd1);
      check("drain_data",  out_data, 32'hA000_0000 + i);
      step();
    end
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Phase/lag walk: leak_out is 1 only after the 2nd accept; 0xFFFFFFFF at phase 3 stays hidden.
    do_reset();
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'hFFFFFFFF;
    release_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i];
      step();
      check("walk_leak", leak_out, (i == 1) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("walk_leak_after", leak_out, 32'd0);

    // Stall with release toggling, then mid-operation reset.
    do_reset();
    release_en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hC000_0001 + i;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      release_en = i[0];
      #1;
      check("stall_valid", {31'b0, out_valid}, {31'b0, i[0]});
      check("stall_head",  out_data, 32'hC000_0001);
      step();
    end
    release_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hC000_0003 + i;
      step();
    end
    in_valid = 1'b0;
    check("stall_overflow", {31'b0, overflow}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("mid_rst_overflow",  {31'b0, overflow},  32'd0);
    check("mid_rst_leak",      leak_out, 32'd0);
    release_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h5555_0000 + i;
      step();
    end
    in_valid = 1'b0;
    check("mid_rst_phase_restart", leak_out, 32'd1);

    // Randomized soak with occasional resets; the model compare runs every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      in_valid   = ($urandom_range(0, 99) < 60);
      release_en = ($urandom_range(0, 99) < 70);
      out_ready  = ($urandom_range(0, 99) < 50);
      case ($urandom_range(0, 3))
        0:       in_data = 32'hFFFFFFFF;
        1:       in_data = 32'h0;
        default: in_data = $urandom;
      endcase
      step();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;

`ifdef DEMO_RX_STATS_EN
    do_reset();
    release_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      in_data = i;
      step();
    end
    check("stats_rx_sat", {16'b0, rx_count}, 32'h0000FFFF);
    release_en = 1'b0;
    for (int i = 0; i < 304; i++) step();
    check("stats_drop_sat", {24'b0, drop_count}, 32'h000000FF);
    in_valid = 1'b0;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
